// File: rtl/ss_sched.sv
// rtl/ss_sched.sv - round-robin two-client scheduler for the shared systolic matmul engine
// Defining SS_SCHED_TIMEOUT_EN adds the WAIT-state completion watchdog (TIMEOUT cycles).
module ss_sched
`ifdef SS_SCHED_TIMEOUT_EN
  #(parameter int TIMEOUT = 64)
`endif
  (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  req_size,
  output logic [1:0]  gnt,
  input  logic        din_valid,
  input  logic [15:0] din,
  output logic        eng_in_valid,
  output logic [15:0] eng_matrix,
  output logic        eng_matrix_size,
  input  logic        eng_out_valid,
  input  logic [39:0] eng_out_value,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [39:0] rsp_value,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic        proto_err,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, GRANT, STREAM, WAIT, RETURN} state_t;

  state_t     state;
  logic       id;
  logic       size;
  logic       last_gnt;
  logic [5:0] word_cnt;
  logic [2:0] res_cnt;
  logic       win;
  logic [5:0] words_tgt;
  logic [2:0] res_tgt;

`ifdef SS_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] timer;
`else
  assign rsp_err = 1'b0;
`endif

  // On a tie the client not granted last wins; a lone requester always wins.
  assign win       = (req == 2'b11) ? ~last_gnt : req[1];
  assign words_tgt = size ? 6'd32 : 6'd8;
  assign res_tgt   = size ? 3'd7 : 3'd3;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      id              <= 1'b0;
      size            <= 1'b0;
      last_gnt        <= 1'b1;
      word_cnt        <= 6'd0;
      res_cnt         <= 3'd0;
      gnt             <= 2'b00;
      eng_in_valid    <= 1'b0;
      eng_matrix      <= 16'd0;
      eng_matrix_size <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_id          <= 1'b0;
      rsp_value       <= 40'd0;
      rsp_last        <= 1'b0;
      proto_err       <= 1'b0;
`ifdef SS_SCHED_TIMEOUT_EN
      rsp_err         <= 1'b0;
      timer           <= '0;
`endif
    end else begin
      gnt             <= 2'b00;
      eng_in_valid    <= 1'b0;
      eng_matrix      <= 16'd0;
      eng_matrix_size <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_last        <= 1'b0;
`ifdef SS_SCHED_TIMEOUT_EN
      rsp_err         <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (eng_out_valid) proto_err <= 1'b1;
          if (|req) begin
            id       <= win;
            size     <= req_size[win];
            last_gnt <= win;
            gnt      <= win ? 2'b10 : 2'b01;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (eng_out_valid) proto_err <= 1'b1;
          word_cnt <= 6'd0;
          state    <= STREAM;
        end
        STREAM: begin
          if (eng_out_valid) proto_err <= 1'b1;
          if (din_valid) begin
            eng_in_valid    <= 1'b1;
            eng_matrix      <= din;
            eng_matrix_size <= size;
            word_cnt        <= word_cnt + 6'd1;
            if (word_cnt + 6'd1 == words_tgt) begin
              state <= WAIT;
`ifdef SS_SCHED_TIMEOUT_EN
              timer <= '0;
`endif
            end
          end else if (word_cnt != 6'd0) begin
            proto_err <= 1'b1;
          end
        end
        WAIT: begin
          if (eng_out_valid) begin
            rsp_valid <= 1'b1;
            rsp_value <= eng_out_value;
            rsp_id    <= id;
            res_cnt   <= 3'd1;
            state     <= RETURN;
          end
`ifdef SS_SCHED_TIMEOUT_EN
          else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_err <= 1'b1;
            rsp_id  <= id;
            state   <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
`endif
        end
        RETURN: begin
          // One extra cycle here after the final result keeps rsp_last in a busy cycle.
          if (res_cnt == res_tgt) begin
            state <= IDLE;
          end else if (eng_out_valid) begin
            rsp_valid <= 1'b1;
            rsp_value <= eng_out_value;
            rsp_id    <= id;
            res_cnt   <= res_cnt + 3'd1;
            if (res_cnt + 3'd1 == res_tgt) rsp_last <= 1'b1;
          end else begin
            proto_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
